// File: rtl/baccarat_deal_sequencer.sv
// Baccarat deal sequencer: card-load strobes, third-card rules and winner lights.
// Optional feature: define WIN_BLINK_EN to blink the winner lights every BLINK_DIV cycles in DONE.
module baccarat_deal_sequencer #(
    parameter int unsigned BLINK_DIV = 4
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win,
    output logic       dealer_win,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        START  = 4'd0,
        P1     = 4'd1,
        D1     = 4'd2,
        P2     = 4'd3,
        D2     = 4'd4,
        EVAL_P = 4'd5,
        P3     = 4'd6,
        EVAL_D = 4'd7,
        D3     = 4'd8,
        DONE   = 4'd9
    } state_t;

    if (BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_bad_blink_div
        $error("BLINK_DIV must be in 1..255");
    end

    state_t state;
    state_t state_next;
    logic   dealer_draw;
    logic   lights_en;

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // Dealer third-card rule, indexed by the dealer's two-card score.
    always_comb begin
        dealer_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
            4'd3:             dealer_draw = (pcard3 != 4'd8);
            4'd4:             dealer_draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             dealer_draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             dealer_draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
            default:          dealer_draw = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            START:  state_next = P1;
            P1:     state_next = D1;
            D1:     state_next = P2;
            P2:     state_next = D2;
            D2:     state_next = EVAL_P;
            EVAL_P: begin
                if (pscore >= 4'd8 || dscore >= 4'd8) begin
                    state_next = DONE;
                end else if (pscore <= 4'd5) begin
                    state_next = P3;
                end else if (dscore <= 4'd5) begin
                    state_next = D3;
                end else begin
                    state_next = DONE;
                end
            end
            P3:     state_next = EVAL_D;
            EVAL_D: state_next = dealer_draw ? D3 : DONE;
            D3:     state_next = DONE;
            DONE:   state_next = DONE;
            default: state_next = START;
        endcase
    end

`ifdef WIN_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

    logic [7:0] blink_cnt;
    logic       blink_on;

    // Held cleared outside DONE, so every entry to DONE starts lit with a fresh count.
    always_ff @(posedge slow_clock) begin
        if (reset || state != DONE) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 8'd1;
        end
    end

    assign lights_en = blink_on;
`else
    assign lights_en = 1'b1;
`endif

    // Outputs are masked by reset so a reset landing mid-round never shows a strobe.
    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        player_win  = 1'b0;
        dealer_win  = 1'b0;
        if (!reset) begin
            load_pcard1 = (state == P1);
            load_pcard2 = (state == P2);
            load_pcard3 = (state == P3);
            load_dcard1 = (state == D1);
            load_dcard2 = (state == D2);
            load_dcard3 = (state == D3);
            if (state == DONE && lights_en) begin
                player_win = (pscore >= dscore);
                dealer_win = (dscore >= pscore);
            end
        end
    end

    assign state_out = state;

endmodule
